muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Iterative multiply/divide sequencer for the CPU execute stage. It accepts one unsigned MUL or DIV request from stage two and runs a shift-add multiply or a restoring divide over `WIDTH` cycles. While it runs, it holds the pipeline through `stall`, then presents a 2·`WIDTH` result for writeback. It is the only sequential owner of the long-latency arithmetic path; the single-cycle ALU is unaffected.

## Interface
- `WIDTH`, 16: operand width in bits; must be ≥ 2.
- `CNT_W`, $clog2(`WIDTH`+1): width of the iteration counter.

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request a new operation; sampled only in IDLE or DONE.
- `op`  in  `md_op_t`  MD_MUL or MD_DIV; sampled with `start`.
- `a`  in  `WIDTH`  multiplicand or dividend.
- `b`  in  `WIDTH`  multiplier or divisor.
- `flush`  in  1  abort any in-flight operation (branch/pipeline flush).
- `busy`  out  1  high in RUN.
- `stall`  out  1  combinational pipeline hold request.
- `done`  out  1  single-cycle pulse in DONE.
- `result_lo`  out  `WIDTH`  product low half or quotient.
- `result_hi`  out  `WIDTH`  product high half or remainder.
- `div_by_zero`  out  1  DIV with `b`==0; valid with `done`, held until next accepted `start`.

## Operation
- States are IDLE, RUN and DONE.
- IDLE:
  - `start` with no `flush`: latch `op`, `a`, `b`, and load counter = `WIDTH`.
  - If DIV with `b`==0, go to DONE and skip RUN.
  - Otherwise go to RUN.
- RUN: one iteration per cycle; counter decrements each cycle. At counter==1 → DONE.
  - MUL: 2·`WIDTH`-bit accumulator. If the multiplier LSB is set, add the multiplicand into the upper half with carry, then shift right by one.
  - DIV: shift {rem, quo} left by one and subtract the divisor from rem. If the result is non-negative, keep it and set the quo LSB; otherwise restore rem.
  - Working registers are separate from the result registers.
- DONE:
  - `done`=1; result registers are loaded on the edge entering DONE.
  - `start` → back-to-back acceptance, same rules as IDLE.
  - No `start` → IDLE.
- Divide by zero: `result_lo`=all ones, `result_hi`=`a`, `div_by_zero`=1.
- `stall` = (IDLE & `start`) | RUN | (DONE & `start`). The requesting instruction is held until its own DONE cycle. `stall` is 0 in DONE unless a new `start` is present.
- `start` while in RUN is ignored.
- `flush`:
  - In any state: go to IDLE next edge, no `done` pulse.
  - The result registers and `div_by_zero` keep the last completed values.
  - `flush` and `start` in the same cycle: `flush` wins and the request is dropped.
- All arithmetic is unsigned and modulo 2^(2·`WIDTH`). The product can never overflow 2·`WIDTH` bits.

## Timing
- Reset values:
  - State IDLE; `busy`, `stall` (with `start`=0), `done` and `div_by_zero` = 0.
  - `result_lo` and `result_hi` = 0; counter = 0.
- Normal latency: `start` accepted at edge 0; RUN on cycles 1..`WIDTH`; DONE and `done` on cycle `WIDTH`+1 (17 for `WIDTH`=16).
- Divide by zero: `done` on cycle 1.
- Results are stable from the DONE cycle until the edge that completes the next operation.
- `rst` mid-operation: abort on that edge and return every output to its reset value.

## Structure
- `md_pkg` contains:
  - `typedef enum logic [0:0] {MD_MUL, MD_DIV} md_op_t`
  - `typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t`
  - The default width constant `MD_WIDTH`=16.
- Sub-module `md_datapath` holds the working registers, counter and the add/subtract step, driven by load/step controls. `muldiv_seq` keeps the state machine, `stall` and the result registers.

## Test plan
- MUL 3×5, `WIDTH`=16:
  - `done` at cycle 17 with `result_lo`=0x000F, `result_hi`=0x0000.
  - `stall` high on cycles 0–16 and low on 17.
- MUL 0xFFFF×0xFFFF → `result_hi`=0xFFFE, `result_lo`=0x0001.
- DIV 100/7 → `result_lo`=14, `result_hi`=2, `div_by_zero`=0 at cycle 17.
- DIV 0x04D2/0 → `done` at cycle 1 with `result_lo`=0xFFFF, `result_hi`=0x04D2, `div_by_zero`=1.
- MUL 9×9 with `flush` at cycle 5:
  - IDLE at cycle 6, no `done`.
  - Results still equal the previous operation's values.
  - A `start`+`flush` in the same cycle is ignored.
- Back-to-back and reset:
  - `start` DIV 50/3 during the DONE of a MUL → second `done` 17 cycles later with 16 and 2.
  - `rst` at cycle 8 of a MUL clears all outputs to zero.

Source files
------------

// File: rtl/md_pkg.sv
// Shared types and defaults for the iterative multiply/divide sequencer.
package md_pkg;

  localparam int MD_WIDTH = 16;

  typedef enum logic [0:0] {MD_MUL, MD_DIV} md_op_t;

  typedef enum logic [1:0] {MD_IDLE, MD_RUN, MD_DONE} md_state_t;

endpackage

// File: rtl/md_datapath.sv
// Working registers, iteration counter and the per-cycle shift-add / restoring-divide step.
module md_datapath
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic               i_step,
  input  md_op_t             i_op,
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_acc_nxt,
  output logic               o_last
);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  md_op_t             r_op;
  logic [CNT_W-1:0]   r_cnt;

  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_rem_sh;
  logic [WIDTH:0]     w_diff;
  logic               w_ge;

  // MUL keeps {partial product, multiplier} in r_acc; DIV keeps {rem, quo}.
  always_comb begin
    w_sum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
    w_rem_sh = r_acc[2*WIDTH-1:WIDTH-1];
    w_diff   = w_rem_sh - {1'b0, r_opnd};
    // rem < divisor, so a wrapped difference always lands with its top bit set
    w_ge     = ~w_diff[WIDTH];
    if (r_op == MD_MUL) begin
      if (r_acc[0]) begin
        o_acc_nxt = {w_sum, r_acc[WIDTH-1:1]};
      end else begin
        o_acc_nxt = {1'b0, r_acc[2*WIDTH-1:1]};
      end
    end else if (w_ge) begin
      o_acc_nxt = {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};
    end else begin
      o_acc_nxt = {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_acc  <= '0;
      r_opnd <= '0;
      r_op   <= MD_MUL;
      r_cnt  <= '0;
    end else if (i_load) begin
      r_op   <= i_op;
      r_opnd <= (i_op == MD_MUL) ? i_a : i_b;
      r_acc  <= {{WIDTH{1'b0}}, ((i_op == MD_MUL) ? i_b : i_a)};
      r_cnt  <= CNT_W'(WIDTH);
    end else if (i_step) begin
      r_acc  <= o_acc_nxt;
      r_cnt  <= r_cnt - CNT_W'(1);
    end
  end

  assign o_last = (r_cnt == CNT_W'(1));

endmodule

// File: rtl/muldiv_seq.sv
// Iterative unsigned MUL/DIV sequencer: control FSM, pipeline stall and result registers.
//   state | meaning
//   IDLE  | waiting for a request
//   RUN   | one datapath iteration per cycle, pipeline held
//   DONE  | results valid, done pulse, may accept the next request
module muldiv_seq
  import md_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  md_op_t           i_op,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_flush,
  output logic             o_busy,
  output logic             o_stall,
  output logic             o_done,
  output logic [WIDTH-1:0] o_result_lo,
  output logic [WIDTH-1:0] o_result_hi,
  output logic             o_div_by_zero
);

  localparam logic [1:0] S_IDLE = MD_IDLE;
  localparam logic [1:0] S_RUN  = MD_RUN;
  localparam logic [1:0] S_DONE = MD_DONE;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic               w_open;
  logic               w_accept;
  logic               w_dbz;
  logic               w_load;
  logic               w_step;
  logic               w_last;
  logic               w_finish;
  logic [2*WIDTH-1:0] w_acc_nxt;

  assign w_open   = (r_state == S_IDLE) || (r_state == S_DONE);
  assign w_accept = i_start && !i_flush && w_open;
  assign w_dbz    = (i_op == MD_DIV) && (i_b == '0);
  assign w_load   = w_accept && !w_dbz;
  assign w_step   = (r_state == S_RUN) && !i_flush;
  assign w_finish = w_step && w_last;

  md_datapath #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_datapath (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_op      (i_op),
    .i_a       (i_a),
    .i_b       (i_b),
    .o_acc_nxt (w_acc_nxt),
    .o_last    (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    if (i_flush) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) w_state_nxt = w_dbz ? S_DONE : S_RUN;
          else          w_state_nxt = S_IDLE;
        end
        S_RUN:   w_state_nxt = w_last ? S_DONE : S_RUN;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Results only change when an operation completes; a flush leaves them alone.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_result_lo   <= '0;
      o_result_hi   <= '0;
      o_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      o_div_by_zero <= w_dbz;
      if (w_dbz) begin
        o_result_lo <= '1;
        o_result_hi <= i_a;
      end
    end else if (w_finish) begin
      o_result_lo <= w_acc_nxt[WIDTH-1:0];
      o_result_hi <= w_acc_nxt[2*WIDTH-1:WIDTH];
    end
  end

  assign o_busy  = (r_state == S_RUN);
  assign o_done  = (r_state == S_DONE);
  assign o_stall = (w_open && i_start) || (r_state == S_RUN);

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed scenarios plus a scoreboard of expected results.
module tb_muldiv_seq;
  import md_pkg::*;

  localparam int W = 16;

  logic         i_clk = 1'b0;
  logic         i_rst = 1'b1;
  logic         i_start = 1'b0;
  md_op_t       i_op = MD_MUL;
  logic [W-1:0] i_a = '0;
  logic [W-1:0] i_b = '0;
  logic         i_flush = 1'b0;
  logic         o_busy, o_stall, o_done, o_div_by_zero;
  logic [W-1:0] o_result_lo, o_result_hi;

  int chk = 0;
  int pass = 0;

  typedef struct {
    logic [W-1:0] lo;
    logic [W-1:0] hi;
    logic         dbz;
    int           lat;
  } exp_t;

  exp_t sb[$];

  muldiv_seq #(.WIDTH(W)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .i_op          (i_op),
    .i_a           (i_a),
    .i_b           (i_b),
    .i_flush       (i_flush),
    .o_busy        (o_busy),
    .o_stall       (o_stall),
    .o_done        (o_done),
    .o_result_lo   (o_result_lo),
    .o_result_hi   (o_result_hi),
    .o_div_by_zero (o_div_by_zero)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [31:0] p;
    if (op == MD_MUL) begin
      p = 32'(a) * 32'(b);
      e.lo = p[15:0]; e.hi = p[31:16]; e.dbz = 1'b0; e.lat = W + 1;
    end else if (b == '0) begin
      e.lo = '1; e.hi = a; e.dbz = 1'b1; e.lat = 1;
    end else begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0; e.lat = W + 1;
    end
    return e;
  endfunction

  // Drives a request in the current cycle; the next rising edge samples it.
  task automatic issue(input md_op_t op, input logic [W-1:0] a, input logic [W-1:0] b, input bit track);
    i_start = 1'b1; i_op = op; i_a = a; i_b = b;
    if (track) sb.push_back(model(op, a, b));
  endtask

  // Advances cycle by cycle until done; returns in the done cycle, posedge+2.
  task automatic wait_done(input int budget, output int cyc, output int stall_lo,
                           output logic stall_at_done, output bit got);
    cyc = 1; stall_lo = 0; got = 1'b0; stall_at_done = 1'bx;
    while (cyc <= budget) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      #1;
      if (o_done) begin
        got = 1'b1; stall_at_done = o_stall;
        break;
      end
      if (!o_stall) stall_lo++;
      cyc++;
    end
  endtask

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    #1; i_rst = 1'b0; #1;
    chk++; if (o_busy !== 1'b0)        $display("FAIL reset busy: got %b want 0", o_busy); else pass++;
    chk++; if (o_stall !== 1'b0)       $display("FAIL reset stall: got %b want 0", o_stall); else pass++;
    chk++; if (o_done !== 1'b0)        $display("FAIL reset done: got %b want 0", o_done); else pass++;
    chk++; if (o_div_by_zero !== 1'b0) $display("FAIL reset dbz: got %b want 0", o_div_by_zero); else pass++;
    chk++; if (o_result_lo !== '0)     $display("FAIL reset lo: got %h want 0", o_result_lo); else pass++;
    chk++; if (o_result_hi !== '0)     $display("FAIL reset hi: got %h want 0", o_result_hi); else pass++;
  endtask

  task automatic test_mul_basic();
    int cyc, slo; logic sd; bit got; exp_t e;
    @(posedge i_clk); #1;
    issue(MD_MUL, 16'd3, 16'd5, 1'b1);
    #1;
    chk++; if (o_stall !== 1'b1) $display("FAIL mul3x5 stall c0: got %b want 1", o_stall); else pass++;
    wait_done(40, cyc, slo, sd, got);
    e = sb.pop_front();
    chk++; if (!got)          $display("FAIL mul3x5 done timeout: got none want cycle %0d", e.lat); else pass++;
    chk++; if (cyc !== e.lat) $display("FAIL mul3x5 latency: got %0d want %0d", cyc, e.lat); else pass++;
    chk++; if (slo !== 0)     $display("FAIL mul3x5 stall low cycles: got %0d want 0", slo); else pass++;
    chk++; if (sd !== 1'b0)   $display("FAIL mul3x5 stall at done: got %b want 0", sd); else pass++;
    chk++; if (o_result_lo !== e.lo) $display("FAIL mul3x5 lo: got %h want %h", o_result_lo, e.lo); else pass++;
    chk++; if (o_result_hi !== e.hi) $display("FAIL mul3x5 hi: got %h want %h", o_result_hi, e.hi); else pass++;
  endtask

  task automatic test_mul_max();
    int cyc, slo; logic sd; bit got; exp_t e;
    @(posedge i_clk); #1;
    issue(MD_MUL, 16'hFFFF, 16'hFFFF, 1'b1);
    wait_done(40, cyc, slo, sd, got);
    e = sb.pop_front();
    chk++; if (!got) $display("FAIL mulmax done timeout: got none want done"); else pass++;
    chk++; if (o_result_lo !== e.lo) $display("FAIL mulmax lo: got %h want %h", o_result_lo, e.lo); else pass++;
    chk++; if (o_result_hi !== e.hi) $display("FAIL mulmax hi: got %h want %h", o_result_hi, e.hi); else pass++;
  endtask

  task automatic test_div();
    int cyc, slo; logic sd; bit got; exp_t e;
    @(posedge i_clk); #1;
    issue(MD_DIV, 16'd100, 16'd7, 1'b1);
    wait_done(40, cyc, slo, sd, got);
    e = sb.pop_front();
    chk++; if (cyc !== e.lat) $display("FAIL div100/7 latency: got %0d want %0d", cyc, e.lat); else pass++;
    chk++; if (o_result_lo !== e.lo) $display("FAIL div100/7 quo: got %0d want %0d", o_result_lo, e.lo); else pass++;
    chk++; if (o_result_hi !== e.hi) $display("FAIL div100/7 rem: got %0d want %0d", o_result_hi, e.hi); else pass++;
    chk++; if (o_div_by_zero !== e.dbz) $display("FAIL div100/7 dbz: got %b want %b", o_div_by_zero, e.dbz); else pass++;
  endtask

  task automatic test_flush();
    int ndone;
    @(posedge i_clk); #1;
    issue(MD_MUL, 16'd9, 16'd9, 1'b0);
    for (int c = 1; c <= 5; c++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (c == 5) i_flush = 1'b1;
    end
    #1;
    chk++; if (o_busy !== 1'b1) $display("FAIL flush busy c5: got %b want 1", o_busy); else pass++;
    @(posedge i_clk); #1; i_flush = 1'b0; #1;
    chk++; if (o_busy !== 1'b0) $display("FAIL flush busy c6: got %b want 0", o_busy); else pass++;
    chk++; if (o_done !== 1'b0) $display("FAIL flush done c6: got %b want 0", o_done); else pass++;
    chk++; if (o_result_lo !== 16'd14) $display("FAIL flush kept lo: got %0d want 14", o_result_lo); else pass++;
    chk++; if (o_result_hi !== 16'd2)  $display("FAIL flush kept hi: got %0d want 2", o_result_hi); else pass++;
    issue(MD_MUL, 16'd4, 16'd4, 1'b0);
    i_flush = 1'b1;
    @(posedge i_clk); #1; i_start = 1'b0; i_flush = 1'b0; #1;
    chk++; if (o_busy !== 1'b0) $display("FAIL start+flush busy: got %b want 0", o_busy); else pass++;
    ndone = 0;
    repeat (20) begin
      @(posedge i_clk); #2;
      if (o_done) ndone++;
    end
    chk++; if (ndone !== 0) $display("FAIL start+flush done pulses: got %0d want 0", ndone); else pass++;
  endtask

  task automatic test_div_zero();
    int cyc, slo; logic sd; bit got; exp_t e;
    @(posedge i_clk); #1;
    issue(MD_DIV, 16'h04D2, 16'h0000, 1'b1);
    wait_done(40, cyc, slo, sd, got);
    e = sb.pop_front();
    chk++; if (cyc !== e.lat) $display("FAIL dbz latency: got %0d want %0d", cyc, e.lat); else pass++;
    chk++; if (o_result_lo !== e.lo) $display("FAIL dbz lo: got %h want %h", o_result_lo, e.lo); else pass++;
    chk++; if (o_result_hi !== e.hi) $display("FAIL dbz hi: got %h want %h", o_result_hi, e.hi); else pass++;
    chk++; if (o_div_by_zero !== e.dbz) $display("FAIL dbz flag: got %b want %b", o_div_by_zero, e.dbz); else pass++;
    @(posedge i_clk); #2;
    chk++; if (o_done !== 1'b0) $display("FAIL dbz done after: got %b want 0", o_done); else pass++;
    chk++; if (o_div_by_zero !== 1'b1) $display("FAIL dbz flag held: got %b want 1", o_div_by_zero); else pass++;
  endtask

  task automatic test_back_to_back();
    int cyc, slo; logic sd; bit got; exp_t e;
    @(posedge i_clk); #1;
    issue(MD_MUL, 16'd7, 16'd6, 1'b1);
    wait_done(40, cyc, slo, sd, got);
    issue(MD_DIV, 16'd50, 16'd3, 1'b1);
    #1;
    chk++; if (o_stall !== 1'b1) $display("FAIL b2b stall in done: got %b want 1", o_stall); else pass++;
    e = sb.pop_front();
    chk++; if (o_result_lo !== e.lo) $display("FAIL b2b mul lo: got %0d want %0d", o_result_lo, e.lo); else pass++;
    chk++; if (o_div_by_zero !== 1'b0) $display("FAIL b2b mul dbz: got %b want 0", o_div_by_zero); else pass++;
    wait_done(40, cyc, slo, sd, got);
    e = sb.pop_front();
    chk++; if (cyc !== e.lat) $display("FAIL b2b div latency: got %0d want %0d", cyc, e.lat); else pass++;
    chk++; if (o_result_lo !== e.lo) $display("FAIL b2b div quo: got %0d want %0d", o_result_lo, e.lo); else pass++;
    chk++; if (o_result_hi !== e.hi) $display("FAIL b2b div rem: got %0d want %0d", o_result_hi, e.hi); else pass++;
  endtask

  task automatic test_rst_mid();
    @(posedge i_clk); #1;
    issue(MD_MUL, 16'h1234, 16'h5678, 1'b0);
    for (int c = 1; c <= 8; c++) begin
      @(posedge i_clk); #1;
      i_start = 1'b0;
      if (c == 8) i_rst = 1'b1;
    end
    @(posedge i_clk); #1; i_rst = 1'b0; #1;
    chk++; if (o_busy !== 1'b0)    $display("FAIL rstmid busy: got %b want 0", o_busy); else pass++;
    chk++; if (o_stall !== 1'b0)   $display("FAIL rstmid stall: got %b want 0", o_stall); else pass++;
    chk++; if (o_done !== 1'b0)    $display("FAIL rstmid done: got %b want 0", o_done); else pass++;
    chk++; if (o_result_lo !== '0) $display("FAIL rstmid lo: got %h want 0", o_result_lo); else pass++;
    chk++; if (o_result_hi !== '0) $display("FAIL rstmid hi: got %h want 0", o_result_hi); else pass++;
  endtask

  task automatic test_random();
    int cyc, slo; logic sd; bit got; exp_t e;
    md_op_t       op;
    logic [W-1:0] a, b;
    for (int n = 0; n < 10; n++) begin
      op = ($urandom_range(0, 1) == 0) ? MD_MUL : MD_DIV;
      a  = W'($urandom);
      b  = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
      @(posedge i_clk); #1;
      issue(op, a, b, 1'b1);
      wait_done(40, cyc, slo, sd, got);
      e = sb.pop_front();
      chk++; if (cyc !== e.lat) $display("FAIL rand%0d latency: got %0d want %0d", n, cyc, e.lat); else pass++;
      chk++; if ({o_div_by_zero, o_result_hi, o_result_lo} !== {e.dbz, e.hi, e.lo})
        $display("FAIL rand%0d op=%0d a=%h b=%h: got dbz=%b %h_%h want dbz=%b %h_%h", n, op, a, b,
                 o_div_by_zero, o_result_hi, o_result_lo, e.dbz, e.hi, e.lo);
      else pass++;
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_mul_max();
    test_div();
    test_flush();
    test_div_zero();
    test_back_to_back();
    test_rst_mid();
    test_random();
    $display("%0d/%0d checks passed", pass, chk);
    $finish;
  end

endmodule
